// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer.
//   SIPO_WIDTH   : default data bits per word
//   state_e      : output register state (empty / holding an unconsumed word)
//   xor_reduce() : even-parity helper over a zero-padded vector
package sipo_pkg;

  localparam int unsigned SIPO_WIDTH = 4;

  // Parity helper operand width; frames up to this many bits are supported.
  localparam int unsigned PARITY_VEC_W = 32;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic logic xor_reduce(input logic [PARITY_VEC_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial capture core: shift register, bit counter and frame-complete strobe.
//   clk, rst_n : clock, synchronous active-low reset
//   in, shift  : serial bit and its qualifier (MSB first)
//   clear      : flush of the partial frame; overrides shift
//   frame      : frame including the bit being sampled this cycle
//   word_done  : high in the cycle whose edge captures the last frame bit
module sipo_shift_core #(
  parameter int unsigned FRAME = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             shift,
  input  logic             clear,
  output logic [FRAME-1:0] frame,
  output logic             word_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  logic [FRAME-1:0] shreg;
  logic [CNT_W-1:0] cnt;

  // The frame presented includes the incoming bit so a completed word can be
  // loaded on the very edge that samples its last bit.
  always_comb begin
    frame     = {shreg[FRAME-2:0], in};
    word_done = shift && !clear && (cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= frame;
      cnt   <= word_done ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver with a valid/ready output register.
// Optional even-parity framing is enabled by defining SIPO_PARITY_EN.
//   clk, rst_n       : clock, synchronous active-low reset
//   in, shift        : serial data bit (MSB first) and capture qualifier
//   clear            : flush any partially received word
//   out, out_valid   : received word and its valid flag
//   out_ready        : consumer accepts out when out_valid is high
//   overrun          : one-cycle pulse when a completed word is dropped
//   parity_err       : one-cycle pulse with a loaded word whose parity is bad
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             shift,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SIPO_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  logic [FRAME-1:0] frame;
  logic             word_done;
  logic [WIDTH-1:0] data;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             overrun_q, overrun_d;
  logic             hs, load;

  sipo_shift_core #(
    .FRAME(FRAME),
    .CNT_W(CNT_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .shift    (shift),
    .clear    (clear),
    .frame    (frame),
    .word_done(word_done)
  );

  // Data bits lead the frame; a trailing parity bit, if any, is dropped.
  assign data = frame[FRAME-1 -: WIDTH];

  always_comb begin
    hs        = (state_q == ST_FULL) && out_ready;
    // Accept a new word if empty or if the held word leaves on this edge.
    load      = word_done && ((state_q == ST_EMPTY) || hs);
    state_d   = state_q;
    out_d     = out_q;
    overrun_d = word_done && !load;
    if (load) begin
      state_d = ST_FULL;
      out_d   = data;
    end else if (hs) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      out_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SIPO_PARITY_EN
  logic [PARITY_VEC_W-1:0] par_vec;
  logic                    perr_q;

  always_comb begin
    par_vec            = '0;
    par_vec[FRAME-1:0] = frame;
  end

  // Dropped words never raise parity_err; only loaded ones are checked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= load && xor_reduce(par_vec);
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign out       = out_q;
  assign out_valid = (state_q == ST_FULL);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed scenarios plus a
// randomized run, all compared against a word-level reference model.
module tb_sipo_deserializer;

  localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F = WIDTH + P;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ser_in = 1'b0;
  logic             shift = 1'b0;
  logic             clear = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] dut_out;
  logic             out_valid, overrun, parity_err;

  int checks = 0;
  int errors = 0;

  // Reference model: frame accumulated as an integer, output as a slot.
  int               m_acc = 0;
  int               m_cnt = 0;
  logic [WIDTH-1:0] m_out = '0;
  bit               m_valid = 0;
  bit               m_ovr = 0;
  bit               m_perr = 0;

  sipo_deserializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (ser_in),
    .shift     (shift),
    .clear     (clear),
    .out       (dut_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
    $fatal(1);
  end

  // Advance one clock edge and move the model by the same edge.
  task automatic tick();
    int               acc;
    int               cnt;
    int               word;
    bit               done;
    bit               hs;
    logic [31:0]      tmp;
    logic [WIDTH-1:0] n_out;
    bit               n_valid, n_ovr, n_perr;
    acc = m_acc; cnt = m_cnt; word = 0; done = 0;
    hs = m_valid && out_ready;
    n_out = m_out; n_valid = m_valid; n_ovr = 0; n_perr = 0;
    if (!rst_n) begin
      acc = 0; cnt = 0; n_out = '0; n_valid = 0;
    end else begin
      if (clear) begin
        acc = 0; cnt = 0;
      end else if (shift) begin
        acc = (acc * 2 + int'(ser_in)) % (1 << F);
        cnt++;
        if (cnt == F) begin
          done = 1; word = acc; cnt = 0;
        end
      end
      if (done && (!m_valid || hs)) begin
        tmp     = 32'(word) >> P;
        n_out   = tmp[WIDTH-1:0];
        n_valid = 1;
        n_perr  = (P == 1) && ($countones(word) % 2 == 1);
      end else if (done) begin
        n_ovr = 1;
      end else if (hs) begin
        n_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    m_acc = acc; m_cnt = cnt; m_out = n_out; m_valid = n_valid;
    m_ovr = n_ovr; m_perr = n_perr;
  endtask

  function automatic bit fbit(input logic [WIDTH-1:0] w, input int k, input bit bad);
    if (k < WIDTH) return w[WIDTH-1-k];
    return (^w) ^ bad;
  endfunction

  // Shift one whole frame (data bits then optional parity); shift stays high.
  task automatic send_word(input logic [WIDTH-1:0] w, input bit bad);
    for (int k = 0; k < F; k++) begin
      shift  = 1'b1;
      ser_in = fbit(w, k, bad);
      tick();
    end
  endtask

  task automatic flush();
    shift = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (dut_out !== '0) begin errors++; $display("FAIL reset_out: got %b, required 0", dut_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b, required 0", parity_err); end
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b, required 0", out_valid); end
  endtask

  task automatic test_basic();
    send_word(4'b1011, 1'b0);
    shift = 1'b0;
    checks++; if (dut_out !== 4'b1011) begin errors++; $display("FAIL basic_out: got %b, required 1011", dut_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b, required 1", out_valid); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b, required 0", parity_err); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consume: got %b, required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    send_word(4'b1011, 1'b0);
    checks++; if (dut_out !== 4'b1011 || out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got %b/%b, required 1011/1", dut_out, out_valid);
    end
    // Consumer takes the first word on the same edge the second completes.
    for (int k = 0; k < F; k++) begin
      ser_in    = fbit(4'b0110, k, 1'b0);
      out_ready = (k == F - 1);
      tick();
      if (k < F - 1) begin
        checks++; if (dut_out !== 4'b1011 || out_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_hold: got %b/%b, required 1011/1", dut_out, out_valid);
        end
      end
    end
    checks++; if (dut_out !== 4'b0110 || out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got %b/%b, required 0110/1", dut_out, out_valid);
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b, required 0", overrun); end
    flush();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b, required 0", out_valid); end
  endtask

  task automatic test_overrun();
    send_word(4'b1100, 1'b0);
    send_word(4'b0011, 1'b0);
    shift = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b, required 1", overrun); end
    checks++; if (dut_out !== 4'b1100 || out_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_keep: got %b/%b, required 1100/1", dut_out, out_valid);
    end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL ovr_perr: got %b, required 0", parity_err); end
    tick();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle: got %b, required 0", overrun); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_dropped: got %b, required 0", out_valid); end
  endtask

  task automatic test_gap_clear();
    shift = 1'b1; ser_in = 1'b1; tick();
    ser_in = 1'b0; tick();
    shift = 1'b0;
    repeat (3) tick();
    for (int k = 2; k < F; k++) begin
      shift = 1'b1; ser_in = fbit(4'b1001, k, 1'b0); tick();
    end
    shift = 1'b0;
    checks++; if (dut_out !== 4'b1001 || out_valid !== 1'b1) begin
      errors++; $display("FAIL gap_word: got %b/%b, required 1001/1", dut_out, out_valid);
    end
    flush();
    // Partial word discarded by clear; the shift in the clear cycle is ignored.
    shift = 1'b1; ser_in = 1'b1;
    repeat (3) tick();
    clear = 1'b1; tick();
    clear = 1'b0;
    send_word(4'b0101, 1'b0);
    shift = 1'b0;
    checks++; if (dut_out !== 4'b0101 || out_valid !== 1'b1) begin
      errors++; $display("FAIL clear_word: got %b/%b, required 0101/1", dut_out, out_valid);
    end
    clear = 1'b1; tick();
    clear = 1'b0;
    checks++; if (dut_out !== 4'b0101 || out_valid !== 1'b1) begin
      errors++; $display("FAIL clear_pending: got %b/%b, required 0101/1", dut_out, out_valid);
    end
    flush();
    // Clear on the edge of the last frame bit wins: nothing is loaded.
    for (int k = 0; k < F - 1; k++) begin
      shift = 1'b1; ser_in = fbit(4'b1110, k, 1'b0); tick();
    end
    ser_in = fbit(4'b1110, F - 1, 1'b0); clear = 1'b1; tick();
    clear = 1'b0; shift = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_last_bit: got %b, required 0", out_valid); end
  endtask

  task automatic test_reset_midword();
    shift = 1'b1; ser_in = 1'b1; tick();
    ser_in = 1'b1; tick();
    shift = 1'b0; rst_n = 1'b0; tick();
    rst_n = 1'b1;
    checks++; if (dut_out !== '0 || out_valid !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got %b/%b/%b/%b, required 0000/0/0/0",
                         dut_out, out_valid, overrun, parity_err);
    end
    send_word(4'b0111, 1'b0);
    shift = 1'b0;
    checks++; if (dut_out !== 4'b0111 || out_valid !== 1'b1) begin
      errors++; $display("FAIL midreset_word: got %b/%b, required 0111/1", dut_out, out_valid);
    end
    flush();
  endtask

  task automatic test_parity();
    send_word(4'b1011, 1'b0);
    shift = 1'b0;
    checks++; if (dut_out !== 4'b1011 || parity_err !== 1'b0) begin
      errors++; $display("FAIL parity_good: got %b/%b, required 1011/0", dut_out, parity_err);
    end
    flush();
    send_word(4'b1011, 1'b1);
    shift = 1'b0;
    checks++; if (dut_out !== 4'b1011 || parity_err !== 1'b1) begin
      errors++; $display("FAIL parity_bad: got %b/%b, required 1011/1", dut_out, parity_err);
    end
    tick();
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_pulse: got %b, required 0", parity_err); end
    flush();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      shift     = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
      ser_in    = $urandom_range(0, 1);
      tick();
      checks++; if (dut_out !== m_out) begin
        errors++; $display("FAIL rand_out[%0d]: got %b, required %b", i, dut_out, m_out);
      end
      checks++; if (out_valid !== m_valid) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b, required %b", i, out_valid, m_valid);
      end
      checks++; if (overrun !== m_ovr) begin
        errors++; $display("FAIL rand_overrun[%0d]: got %b, required %b", i, overrun, m_ovr);
      end
      checks++; if (parity_err !== m_perr) begin
        errors++; $display("FAIL rand_perr[%0d]: got %b, required %b", i, parity_err, m_perr);
      end
    end
    rst_n = 1'b1; clear = 1'b0; shift = 1'b0; out_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_gap_clear();
    test_reset_midword();
    if (P == 1) test_parity();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
